// File: rtl/pong_pkg.sv
// Shared types and constants for the pong video pipeline.
// The VGA bus bundle travels through every draw stage unchanged in shape.
package pong_pkg;

    localparam int unsigned SPRITE_SIZE = 16;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned HC_W        = 11;
    localparam int unsigned VC_W        = 11;
    localparam int unsigned RGB_W       = 12;

    localparam logic [RGB_W-1:0] KEY_COLOR_DEFAULT = 12'h000;

    typedef struct packed {
        logic [HC_W-1:0]  hcount;
        logic [VC_W-1:0]  vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
        logic [RGB_W-1:0] rgb;
    } vga_bus_t;

    // One extra bit of headroom so lo + size never wraps for 11-bit positions.
    function automatic logic in_span(input logic [11:0] pos, input logic [11:0] lo,
                                     input logic [11:0] size);
        return (pos >= lo) && (pos < lo + size);
    endfunction

endpackage

// File: rtl/signal_delay.sv
// Fixed-depth shift register with asynchronous active-high reset.
// Used to align the VGA bundle and sprite hit flag with the ROM read latency.
module signal_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d[0] = data_in;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign data_out = stage_q[DEPTH-1];

endmodule

// File: rtl/ball_sprite_ctl.sv
// Ball sprite overlay: latches the ball position once per frame, addresses the
// 16x16 ball ROM and composes the returned pixel over the background stream.
module ball_sprite_ctl
    import pong_pkg::*;
#(
    parameter int unsigned       SPR_SIZE  = SPRITE_SIZE,
    parameter logic [RGB_W-1:0]  KEY_COLOR = KEY_COLOR_DEFAULT,
    parameter logic [HC_W-1:0]   INIT_X    = 11'd504,
    parameter logic [VC_W-1:0]   INIT_Y    = 11'd376,
    parameter int unsigned       PIPE_LAT  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HC_W-1:0]   hcount_in,
    input  logic [VC_W-1:0]   vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hblnk_in,
    input  logic              vblnk_in,
    input  logic [RGB_W-1:0]  rgb_in,
    input  logic [HC_W-1:0]   xpos,
    input  logic [VC_W-1:0]   ypos,
    input  logic              ball_en,
    input  logic [RGB_W-1:0]  ball_color,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [RGB_W-1:0]  rom_color1,
    output logic [RGB_W-1:0]  rom_color2,
    input  logic [RGB_W-1:0]  rom_rgb,
    output logic [HC_W-1:0]   hcount_out,
    output logic [VC_W-1:0]   vcount_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out,
    output logic [RGB_W-1:0]  rgb_out
);

    localparam int unsigned REL_W = $clog2(SPR_SIZE);

    // Frame latch
    logic             vblnk_prev_q;
    logic [HC_W-1:0]  x_l_q, x_l_d;
    logic [VC_W-1:0]  y_l_q, y_l_d;
    logic             en_l_q, en_l_d;
    logic             vblnk_rise;

    // Pipeline
    logic [REL_W-1:0]  rel_x, rel_y;
    logic              in_box;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    vga_bus_t          bus_in, bus_d2;
    logic              in_box_d2;
    vga_bus_t          out_q, out_d;

    assign vblnk_rise = vblnk_in & ~vblnk_prev_q;

    // Position only moves on the vblank rising edge so a frame never tears.
    always_comb begin
        x_l_d  = x_l_q;
        y_l_d  = y_l_q;
        en_l_d = en_l_q;
        if (vblnk_rise) begin
            x_l_d  = xpos;
            y_l_d  = ypos;
            en_l_d = ball_en;
        end
    end

    assign rel_x = hcount_in[REL_W-1:0] - x_l_q[REL_W-1:0];
    assign rel_y = vcount_in[REL_W-1:0] - y_l_q[REL_W-1:0];

    assign in_box = en_l_q
                 && in_span({1'b0, hcount_in}, {1'b0, x_l_q}, 12'(SPR_SIZE))
                 && in_span({1'b0, vcount_in}, {1'b0, y_l_q}, 12'(SPR_SIZE));

    always_comb begin
        rom_addr_d = '0;
        if (in_box) begin
            rom_addr_d = ADDR_W'({rel_y, rel_x});
        end
    end

    assign bus_in = '{
        hcount: hcount_in,
        vcount: vcount_in,
        hsync:  hsync_in,
        vsync:  vsync_in,
        hblnk:  hblnk_in,
        vblnk:  vblnk_in,
        rgb:    rgb_in
    };

    // Bundle and hit flag wait out the address register plus the ROM read.
    signal_delay #(
        .WIDTH ($bits(vga_bus_t)),
        .DEPTH (PIPE_LAT - 1)
    ) u_bus_delay (
        .clk      (clk),
        .rst      (rst),
        .data_in  (bus_in),
        .data_out (bus_d2)
    );

    signal_delay #(
        .WIDTH (1),
        .DEPTH (PIPE_LAT - 1)
    ) u_in_box_delay (
        .clk      (clk),
        .rst      (rst),
        .data_in  (in_box),
        .data_out (in_box_d2)
    );

    always_comb begin
        out_d = bus_d2;
        if (bus_d2.hblnk || bus_d2.vblnk) begin
            out_d.rgb = '0;
        end else if (in_box_d2 && (rom_rgb != KEY_COLOR)) begin
            out_d.rgb = rom_rgb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_prev_q <= 1'b0;
            x_l_q        <= INIT_X;
            y_l_q        <= INIT_Y;
            en_l_q       <= 1'b0;
            rom_addr_q   <= '0;
            out_q        <= '0;
        end else begin
            vblnk_prev_q <= vblnk_in;
            x_l_q        <= x_l_d;
            y_l_q        <= y_l_d;
            en_l_q       <= en_l_d;
            rom_addr_q   <= rom_addr_d;
            out_q        <= out_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign rom_color1 = KEY_COLOR;
    assign rom_color2 = ball_color;

    assign hcount_out = out_q.hcount;
    assign vcount_out = out_q.vcount;
    assign hsync_out  = out_q.hsync;
    assign vsync_out  = out_q.vsync;
    assign hblnk_out  = out_q.hblnk;
    assign vblnk_out  = out_q.vblnk;
    assign rgb_out    = out_q.rgb;

endmodule

// File: tb/tb_ball_sprite_ctl.sv
// Randomised bench for ball_sprite_ctl: a pixel-level reference model predicts
// the ROM address and the composed output for every driven pixel.
module tb_ball_sprite_ctl;

    localparam int SPR    = 16;
    localparam int INIT_X = 504;
    localparam int INIT_Y = 376;

    logic        clk;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] xpos, ypos;
    logic        ball_en;
    logic [11:0] ball_color;
    logic [7:0]  rom_addr;
    logic [11:0] rom_color1, rom_color2;
    logic [11:0] rom_rgb;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    ball_sprite_ctl dut (
        .clk        (clk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .xpos       (xpos),
        .ypos       (ypos),
        .ball_en    (ball_en),
        .ball_color (ball_color),
        .rom_addr   (rom_addr),
        .rom_color1 (rom_color1),
        .rom_color2 (rom_color2),
        .rom_rgb    (rom_rgb),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ball image: bit set means ball pixel (color2), clear means key (color1).
    bit rom_mask [256];

    initial rom_rgb = '0;
    always @(posedge clk) rom_rgb <= rom_mask[rom_addr] ? rom_color2 : rom_color1;

    // Reference model state
    int  lx, ly;
    bit  len, prev_vb;
    logic [37:0] q_out [$];

    int n_pass;
    int n_checks;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        lx      = INIT_X;
        ly      = INIT_Y;
        len     = 1'b0;
        prev_vb = 1'b0;
        q_out.delete();
        q_out.push_back('0);
        q_out.push_back('0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_rgb"}, rgb_out, 0);
        check_val({tag, "_addr"}, rom_addr, 0);
        check_val({tag, "_timing"},
                  {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 0);
    endtask

    // Drive one pixel, predict its results, then check after the active edge.
    task automatic drive_cycle(input int h, input int v, input bit hb, input bit vb,
                               input int xp, input int yp, input bit en);
        bit          inbox;
        int          ex_addr;
        logic [11:0] ex_rgb;
        logic [37:0] e;
        @(negedge clk);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = hb;
        vblnk_in  = vb;
        hsync_in  = 1'($urandom);
        vsync_in  = 1'($urandom);
        rgb_in    = 12'($urandom);
        xpos      = 11'(xp);
        ypos      = 11'(yp);
        ball_en   = en;

        inbox   = len && (h >= lx) && (h < lx + SPR) && (v >= ly) && (v < ly + SPR);
        ex_addr = inbox ? (v - ly) * SPR + (h - lx) : 0;
        if (hb || vb) ex_rgb = '0;
        else if (inbox && rom_mask[ex_addr]) ex_rgb = ball_color;
        else ex_rgb = rgb_in;
        q_out.push_back({hcount_in, vcount_in, hsync_in, vsync_in, hb, vb, ex_rgb});

        if (vb && !prev_vb) begin
            lx  = xp;
            ly  = yp;
            len = en;
        end
        prev_vb = vb;

        @(posedge clk);
        #1;
        check_val("rom_addr", rom_addr, ex_addr);
        e = q_out.pop_front();
        check_val("timing_out",
                  {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out},
                  e[37:12]);
        check_val("rgb_out", rgb_out, e[11:0]);
    endtask

    // Entered just after an active edge; asserts reset between edges.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1 check_outputs_zero("rst_async");
        repeat (2) @(posedge clk);
        #1 check_outputs_zero("rst_held");
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Active lines covering a window, then two vblank lines; the next target
    // position is presented only on the first vblank cycle.
    task automatic run_frame(input int h0, input int hn, input int v0, input int vn,
                             input int nx, input int ny, input bit nen, input int rst_line);
        int v;
        int h;
        for (int l = 0; l < vn; l++) begin
            v = v0 + l;
            drive_cycle(0, v, 1'b0, 1'b0, $urandom_range(0, 2047), $urandom_range(0, 2047),
                        1'($urandom));
            for (int i = 0; i < hn; i++) begin
                h = h0 + i;
                drive_cycle(h, v, h >= 1024, 1'b0, $urandom_range(0, 2047),
                            $urandom_range(0, 2047), 1'($urandom));
                if (l == rst_line && i == hn / 2) async_reset();
            end
            for (int i = 0; i < 3; i++) begin
                drive_cycle(1024 + i, v, 1'b1, 1'b0, $urandom_range(0, 2047),
                            $urandom_range(0, 2047), 1'($urandom));
            end
        end
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 20; i++) begin
                if (l == 0 && i == 0)
                    drive_cycle(1030 + i, 768 + l, 1'($urandom), 1'b1, nx, ny, nen);
                else
                    drive_cycle(1030 + i, 768 + l, 1'($urandom), 1'b1,
                                $urandom_range(0, 2047), $urandom_range(0, 2047),
                                1'($urandom));
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cx, cy, nx, ny;
        n_pass   = 0;
        n_checks = 0;
        rst       = 1'b1;
        hcount_in = '0;
        vcount_in = '0;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        hblnk_in  = 1'b0;
        vblnk_in  = 1'b0;
        rgb_in    = '0;
        xpos      = '0;
        ypos      = '0;
        ball_en   = 1'b0;
        ball_color = 12'($urandom_range(1, 4095));
        for (int i = 0; i < 256; i++) rom_mask[i] = ($urandom_range(0, 9) != 0);
        rom_mask[0]     = 1'b0;
        rom_mask[8'h35] = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        check_val("rom_color1", rom_color1, 12'h000);
        check_val("rom_color2", rom_color2, ball_color);
        #1 rst = 1'b0;
        model_reset();

        run_frame(90, 41, 45, 26, 100, 50, 1'b1, -1);    // hidden: en not yet latched
        run_frame(90, 41, 45, 26, 300, 50, 1'b1, -1);    // ball at 100,50
        run_frame(290, 41, 45, 26, 1020, 60, 1'b1, -1);  // ball at 300,50
        run_frame(1005, 30, 55, 26, 200, 100, 1'b0, -1); // ball clipped at right edge
        run_frame(190, 40, 95, 26, 400, 300, 1'b1, -1);  // disabled
        run_frame(390, 40, 295, 26, 400, 300, 1'b1, 10); // reset mid-frame
        cx = 400;
        cy = 300;
        for (int f = 0; f < 5; f++) begin
            nx = $urandom_range(0, 1030);
            ny = $urandom_range(0, 760);
            run_frame((cx > 8) ? cx - 8 : 0, 36, (cy > 4) ? cy - 4 : 0, 24, nx, ny,
                      ($urandom_range(0, 3) != 0), -1);
            cx = nx;
            cy = ny;
        end
        check_val("rom_color2_end", rom_color2, ball_color);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
